// File: rtl/inj_fifo_nic.sv
// Injection NIC: drops self-addressed words, queues the rest in a FWFT FIFO; head visible 1 cycle after push, source is never stalled (overflow drops + sticky ovf).
// Router side is valid/ready; optional INJ_STATS_EN adds saturating accept/drop/self counters.
module inj_fifo_nic #(
  parameter int unsigned DATA_W  = 20,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned SELF_ID = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf
`ifdef INJ_STATS_EN
  ,
  output logic [15:0]       acc_cnt,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       self_cnt
`endif
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [3:0]      SELF    = SELF_ID[3:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              self_hit;
  logic              push;
  logic              pop;
  logic              drop;

  // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];
  assign out_dest  = out_data[3:0];

  assign self_hit = in_valid && (in_data[3:0] == SELF);
  assign pop      = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push     = in_valid && !self_hit && (!full || pop);
  assign drop     = in_valid && !self_hit && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (drop) ovf    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= in_data;
  end

`ifdef INJ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt  <= '0;
      drop_cnt <= '0;
      self_cnt <= '0;
    end else begin
      if (push     && acc_cnt  != 16'hFFFF) acc_cnt  <= acc_cnt  + 16'd1;
      if (drop     && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (self_hit && self_cnt != 16'hFFFF) self_cnt <= self_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inj_fifo_nic.sv
// Bench for inj_fifo_nic: directed scenarios then random traffic, all checked against a queue model.
module tb_inj_fifo_nic;
  localparam int DATA_W = 20;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_dest;
  logic              out_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              ovf;
`ifdef INJ_STATS_EN
  logic [15:0]       acc_cnt;
  logic [15:0]       drop_cnt;
  logic [15:0]       self_cnt;
`endif

  always #5 clk = ~clk;

  inj_fifo_nic #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SELF_ID(0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_dest(out_dest), .out_valid(out_valid), .out_ready(out_ready),
    .full(full), .empty(empty), .count(count), .ovf(ovf)
`ifdef INJ_STATS_EN
    , .acc_cnt(acc_cnt), .drop_cnt(drop_cnt), .self_cnt(self_cnt)
`endif
  );

  // Reference model: a plain queue of stored words plus sticky overflow and counters.
  logic [DATA_W-1:0] q[$];
  bit                m_ovf = 0;
  int                m_acc = 0, m_drop = 0, m_self = 0;
  int                errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DATA_W-1:0] head;
    head = (q.size() != 0) ? q[0] : '0;
    chk({tag, ".valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, ".data"},  32'(out_data),  32'(head));
    chk({tag, ".dest"},  32'(out_dest),  32'(head[3:0]));
    chk({tag, ".count"}, 32'(count),     32'(q.size()));
    chk({tag, ".full"},  32'(full),      32'(q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(empty),     32'(q.size() == 0));
    chk({tag, ".ovf"},   32'(ovf),       32'(m_ovf));
`ifdef INJ_STATS_EN
    chk({tag, ".acc"},   32'(acc_cnt),   32'(m_acc));
    chk({tag, ".drop"},  32'(drop_cnt),  32'(m_drop));
    chk({tag, ".self"},  32'(self_cnt),  32'(m_self));
`endif
  endtask

  // Called at a falling edge; applies inputs across one rising edge, then checks at the next falling edge.
  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit r, input string tag);
    bit                had_room, popped, self_w;
    logic [DATA_W-1:0] tmp;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    popped   = (q.size() != 0) && r;
    had_room = (q.size() < DEPTH) || popped;
    self_w   = v && (d[3:0] == 4'd0);
    if (popped) tmp = q.pop_front();
    if (self_w) m_self = (m_self < 65535) ? m_self + 1 : m_self;
    else if (v && had_room) begin
      q.push_back(d);
      m_acc = (m_acc < 65535) ? m_acc + 1 : m_acc;
    end else if (v) begin
      m_ovf  = 1;
      m_drop = (m_drop < 65535) ? m_drop + 1 : m_drop;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_all(tag);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    chk({tag, ".rst_count"}, 32'(count),     32'd0);
    chk({tag, ".rst_empty"}, 32'(empty),     32'd1);
    chk({tag, ".rst_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".rst_ovf"},   32'(ovf),       32'd0);
    q.delete();
    m_ovf = 0; m_acc = 0; m_drop = 0; m_self = 0;
    in_valid = 1'b1;
    in_data  = 20'h0ABC5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    check_all({tag, ".post"});
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    int max_cnt;

    // Reset state
    #1;
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.empty", 32'(empty), 32'd1);
    chk("reset.full",  32'(full),  32'd0);
    chk("reset.valid", 32'(out_valid), 32'd0);
    chk("reset.data",  32'(out_data),  32'd0);
    chk("reset.ovf",   32'(ovf),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    check_all("reset");

    // Single word, no same-cycle bypass, one-cycle latency
    cycle(1, 20'h02013, 0, "t1");
    chk("t1.data_const", 32'(out_data), 32'h02013);
    chk("t1.dest_const", 32'(out_dest), 32'd3);
    chk("t1.count_const", 32'(count), 32'd1);
    cycle(0, '0, 1, "t1.drain");

    // Fill to full, drop the ninth, drain in order
    for (int i = 0; i < 8; i++) cycle(1, 20'h02013 + DATA_W'(i * 16), 0, "t2.fill");
    chk("t2.full_const", 32'(full), 32'd1);
    chk("t2.count_const", 32'(count), 32'd8);
    cycle(1, 20'h02093, 0, "t2.ninth");
    chk("t2.ovf_const", 32'(ovf), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t2.order", 32'(out_data), 32'h02013 + 32'(i * 16));
      cycle(0, '0, 1, "t2.drain");
    end
    chk("t2.empty_const", 32'(empty), 32'd1);

    // Full with simultaneous push and pop
    async_reset("t3r");
    for (int i = 0; i < 8; i++) cycle(1, 20'h02013 + DATA_W'(i * 16), 0, "t3.fill");
    cycle(1, 20'h020A3, 1, "t3.pushpop");
    chk("t3.count_const", 32'(count), 32'd8);
    chk("t3.ovf_const", 32'(ovf), 32'd0);
    chk("t3.head_const", 32'(out_data), 32'h02023);

    // Self-addressed word while full: discarded, never counted as overflow
    cycle(1, 20'h02010, 0, "t4.self");
    chk("t4.count_const", 32'(count), 32'd8);
    chk("t4.ovf_const", 32'(ovf), 32'd0);
`ifdef INJ_STATS_EN
    chk("t4.self_const", 32'(self_cnt), 32'd1);
`endif
    for (int i = 0; i < 8; i++) cycle(0, '0, 1, "t4.drain");
    cycle(1, 20'h05550, 1, "t4.self_empty");
    chk("t4.empty_const", 32'(empty), 32'd1);

    // Streaming at full rate with continuous ready
    max_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      d = {16'(16'h3000 + i), 4'(1 + (i % 15))};
      cycle(1, d, 1, "t5.stream");
      chk("t5.head", 32'(out_data), 32'(d));
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    chk("t5.max_count", 32'(max_cnt), 32'd1);
    chk("t5.ovf_const", 32'(ovf), 32'd0);
    cycle(0, '0, 1, "t5.drain");

    // Mid-stream reset flushes contents
    for (int i = 0; i < 5; i++) cycle(1, 20'h04401 + DATA_W'(i * 16), 0, "t6.fill");
    chk("t6.count_const", 32'(count), 32'd5);
    async_reset("t6r");
    cycle(1, 20'h07777, 0, "t6.after");
    chk("t6.first_const", 32'(out_data), 32'h07777);

    // Random traffic, alternating phases of slow and fast draining
    for (int i = 0; i < 400; i++) begin
      d = 20'($urandom);
      if ($urandom_range(0, 4) == 0) d[3:0] = 4'd0;
      cycle($urandom_range(0, 3) != 0, d,
            ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
